i2s_rx: RTL

//  I2S receiver: deserialises a stereo I2S stream (ADC or codec output) into parallel

---
 rtl/i2s_rx.sv | 109 ++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples async sck/lrck/sdin in the clk domain and delivers
// completed stereo frames (left then right) on a valid/ready interface.
module i2s_rx #(
   parameter int unsigned WIDTH       = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sck,
   input  logic             lrck,
   input  logic             sdin,
   output logic [WIDTH-1:0] out_left,
   output logic [WIDTH-1:0] out_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             locked
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [SYNC_STAGES-1:0] sck_sync, lrck_sync, sdin_sync;
   logic                   sck_s, lrck_s, sdin_s, sck_prev;
   logic                   l_prev, primed, left_have;
   logic [WIDTH-1:0]       shreg, left_hold;
   logic [CW-1:0]          bit_cnt;

   logic                   sck_rise, ch_edge, commit_left, commit_right, frame, load;
   logic [WIDTH-1:0]       shifted, aligned;
   logic [CW-1:0]          cnt_next;

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign lrck_s = lrck_sync[SYNC_STAGES-1];
   assign sdin_s = sdin_sync[SYNC_STAGES-1];

   always_comb begin
      shifted  = shreg;
      cnt_next = bit_cnt;
      if (bit_cnt < CW'(WIDTH)) begin
         shifted  = {shreg[WIDTH-2:0], sdin_s};
         cnt_next = bit_cnt + 1'b1;
      end
      // short slots end up left-aligned with zero low bits
      aligned      = shifted << (CW'(WIDTH) - cnt_next);
      sck_rise     = sck_s & ~sck_prev;
      // first rise after reset only primes l_prev so reset cannot fake an lrck edge
      ch_edge      = sck_rise & primed & (lrck_s != l_prev);
      commit_left  = ch_edge & locked & ~l_prev;
      commit_right = ch_edge & locked & l_prev;
      frame        = commit_right & left_have;
      load         = frame & (~out_valid | out_ready);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_sync  <= '0;
         lrck_sync <= '0;
         sdin_sync <= '0;
         sck_prev  <= 1'b0;
         l_prev    <= 1'b0;
         primed    <= 1'b0;
         left_have <= 1'b0;
         shreg     <= '0;
         left_hold <= '0;
         bit_cnt   <= '0;
         out_left  <= '0;
         out_right <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         locked    <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
         sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
         sck_prev  <= sck_s;
         overflow  <= 1'b0;

         if (out_valid && out_ready)
            out_valid <= 1'b0;

         if (sck_rise) begin
            l_prev <= lrck_s;
            primed <= 1'b1;
            shreg  <= shifted;
            if (ch_edge) begin
               bit_cnt <= '0;
               locked  <= 1'b1;
               if (commit_left) begin
                  left_hold <= aligned;
                  left_have <= 1'b1;
               end
               if (commit_right)
                  left_have <= 1'b0;
            end else begin
               bit_cnt <= cnt_next;
            end
         end

         if (load) begin
            out_left  <= left_hold;
            out_right <= aligned;
            out_valid <= 1'b1;
         end else if (frame) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule
